// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - raster frame sequencer feeding pixels to the Hough datapath
//
// Purpose:
//   Accepts a frame request, latches its dimensions and pulls Width x Height
//   pixels from a valid/ready source. Each accepted pixel is re-emitted one
//   cycle later with line/frame start markers. A Done pulse follows the frame.
//
// Ports:
//   Clk        in   sole clock, rising edge
//   Reset      in   synchronous, active-high
//   Start      in   frame request (honoured in IDLE only)
//   Abort      in   cancel current frame, return to IDLE
//   Width      in   [7:0] pixels per line, latched on Start
//   Height     in   [7:0] lines per frame, latched on Start
//   SrcPixel   in   [PIX_W-1:0] source pixel
//   SrcValid   in   source pixel valid
//   SrcReady   out  sequencer can accept a pixel (state decode only)
//   PixelOut   out  [PIX_W-1:0] registered pixel
//   PixValid   out  PixelOut carries a new pixel this cycle
//   FrameOut   out  first pixel of the frame
//   LineOut    out  first pixel of a line
//   Busy       out  frame in progress
//   Done       out  one-cycle frame completion pulse
//
// Optional feature:
//   FRAME_SEQUENCER_BLANKING_EN - when defined, inserts BLANK idle cycles
//   (SrcReady=0) between lines. When undefined, lines run back-to-back and
//   the BLANK parameter has no effect.

module frame_sequencer #(
  parameter int PIX_W = 8,
  parameter int BLANK = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [7:0]       Width,
  input  logic [7:0]       Height,
  input  logic [PIX_W-1:0] SrcPixel,
  input  logic             SrcValid,
  output logic             SrcReady,
  output logic [PIX_W-1:0] PixelOut,
  output logic             PixValid,
  output logic             FrameOut,
  output logic             LineOut,
  output logic             Busy,
  output logic             Done
);

  if (BLANK < 1 || BLANK > 255) begin : g_blank_range
    $error("frame_sequencer: BLANK must be within 1..255");
  end

`ifdef FRAME_SEQUENCER_BLANKING_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LINE  = 2'd1,
    S_DONE  = 2'd2,
    S_BLANK = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LINE  = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  state_t     state;
  state_t     next_state;
  logic [7:0] x_cnt;
  logic [7:0] y_cnt;
  logic [7:0] width_q;
  logic [7:0] height_q;
  logic       xfer;
  logic       last_x;
  logic       last_y;
  logic       zero_dim;
  logic       next_busy;

  assign SrcReady = (state == S_LINE);

  // Abort wins over a pending handshake, so an aborted transfer is dropped
  // rather than emitted.
  assign xfer     = (state == S_LINE) && SrcValid && !Abort;
  assign last_x   = (x_cnt == (width_q - 8'd1));
  assign last_y   = (y_cnt == (height_q - 8'd1));
  assign zero_dim = (Width == 8'd0) || (Height == 8'd0);

`ifdef FRAME_SEQUENCER_BLANKING_EN
  logic [7:0] blank_cnt;
  logic       blank_done;

  assign blank_done = (blank_cnt == 8'd0);

  // Loaded with BLANK-1 on the last pixel of a non-final line; the BLANK
  // state lasts while it counts down to zero, i.e. exactly BLANK cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      blank_cnt <= 8'd0;
    end else if (xfer && last_x && !last_y) begin
      blank_cnt <= 8'(BLANK - 1);
    end else if ((state == S_BLANK) && !blank_done) begin
      blank_cnt <= blank_cnt - 8'd1;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          next_state = zero_dim ? S_DONE : S_LINE;
        end
      end
      S_LINE: begin
        if (xfer && last_x) begin
          if (last_y) begin
            next_state = S_DONE;
          end else begin
`ifdef FRAME_SEQUENCER_BLANKING_EN
            next_state = S_BLANK;
`else
            next_state = S_LINE;
`endif
          end
        end
      end
`ifdef FRAME_SEQUENCER_BLANKING_EN
      S_BLANK: begin
        if (blank_done) begin
          next_state = S_LINE;
        end
      end
`endif
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
    if (Abort) begin
      next_state = S_IDLE;
    end
  end

  always_comb begin
    next_busy = (next_state == S_LINE);
`ifdef FRAME_SEQUENCER_BLANKING_EN
    if (next_state == S_BLANK) begin
      next_busy = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_cnt    <= 8'd0;
      y_cnt    <= 8'd0;
      width_q  <= 8'd0;
      height_q <= 8'd0;
      PixelOut <= '0;
      PixValid <= 1'b0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      PixValid <= xfer;
      LineOut  <= xfer && (x_cnt == 8'd0);
      FrameOut <= xfer && (x_cnt == 8'd0) && (y_cnt == 8'd0);
      Busy     <= next_busy;
      // Done trails the one-cycle DONE state so it lands after the last pixel.
      Done     <= (state == S_DONE) && !Abort;
      if (xfer) begin
        PixelOut <= SrcPixel;
      end
      if ((state == S_IDLE) && Start && !Abort) begin
        width_q  <= Width;
        height_q <= Height;
        x_cnt    <= 8'd0;
        y_cnt    <= 8'd0;
      end else if (xfer) begin
        if (last_x) begin
          x_cnt <= 8'd0;
          if (!last_y) begin
            y_cnt <= y_cnt + 8'd1;
          end
        end else begin
          x_cnt <= x_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer

module tb_frame_sequencer;

  localparam int PIX_W   = 8;
  localparam int BLANK_P = 3;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic             Abort;
  logic [7:0]       Width;
  logic [7:0]       Height;
  logic [PIX_W-1:0] SrcPixel;
  logic             SrcValid;
  logic             SrcReady;
  logic [PIX_W-1:0] PixelOut;
  logic             PixValid;
  logic             FrameOut;
  logic             LineOut;
  logic             Busy;
  logic             Done;

  frame_sequencer #(
    .PIX_W(PIX_W),
    .BLANK(BLANK_P)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Abort    (Abort),
    .Width    (Width),
    .Height   (Height),
    .SrcPixel (SrcPixel),
    .SrcValid (SrcValid),
    .SrcReady (SrcReady),
    .PixelOut (PixelOut),
    .PixValid (PixValid),
    .FrameOut (FrameOut),
    .LineOut  (LineOut),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  // ctl = {rst, start, abort}; flags = {sr, pv, fo, lo, busy, done}
  typedef struct {
    logic [2:0] ctl;
    logic [7:0] w;
    logic [7:0] h;
    logic       sv;
    logic [7:0] pix;
    logic [5:0] flags;
    logic [7:0] po;
  } vec_t;

  vec_t vecs[$];

  int   tests = 0;
  int   fails = 0;
  int   xfers;
  int   guard;
  int   idx;
  int   pvn;
  int   bad;
  int   done_at;
  int   cnt_pv;
  int   cnt_dn;
  logic xr;
  logic [14:1] pat;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic [2:0] ctl, input logic [7:0] w, input logic [7:0] h,
                   input logic sv, input logic [7:0] pix, input logic [5:0] flags,
                   input logic [7:0] po);
    vec_t r;
    r.ctl = ctl; r.w = w; r.h = h; r.sv = sv; r.pix = pix; r.flags = flags; r.po = po;
    vecs.push_back(r);
  endtask

  task automatic run_frame(input int w, input int h, input string tag);
    int   pv = 0;
    int   fo = 0;
    int   lo = 0;
    int   dn = 0;
    int   err = 0;
    int   k = 0;
    int   limit;
    logic rdy;
    Width = 8'(w); Height = 8'(h); SrcValid = 1'b1; SrcPixel = 8'h00; Abort = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    limit = w * h + h * (BLANK_P + 1) + 10;
    for (int n = 0; n < limit && dn == 0; n++) begin
      SrcPixel = 8'(k);
      rdy = SrcReady;
      step();
      if (rdy) k++;
      if (PixValid) begin
        if (PixelOut !== 8'(pv)) err++;
        if (FrameOut !== (pv == 0)) err++;
        pv++;
      end
      if (LineOut) lo++;
      if (FrameOut) fo++;
      if (Done) dn++;
    end
    chk($sformatf("%s pixel count", tag), pv, w * h);
    chk($sformatf("%s line starts", tag), lo, h);
    chk($sformatf("%s frame starts", tag), fo, 1);
    chk($sformatf("%s order errors", tag), err, 0);
    chk($sformatf("%s done seen", tag), dn, 1);
    step();
    chk($sformatf("%s done one cycle", tag), Done, 1'b0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Width = 8'd0; Height = 8'd0;
    SrcValid = 1'b0; SrcPixel = 8'h00;

`ifndef FRAME_SEQUENCER_BLANKING_EN
    v(3'b100, 8'd0, 8'd0, 1'b0, 8'h00, 6'b000000, 8'h00);
    v(3'b011, 8'd4, 8'd2, 1'b1, 8'hAA, 6'b000000, 8'h00);
    v(3'b010, 8'd4, 8'd2, 1'b1, 8'hAA, 6'b100010, 8'h00);
    v(3'b000, 8'd9, 8'd9, 1'b1, 8'h10, 6'b111110, 8'h10);
    v(3'b000, 8'd9, 8'd9, 1'b1, 8'h11, 6'b110010, 8'h11);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h12, 6'b110010, 8'h12);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h13, 6'b110010, 8'h13);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h14, 6'b110110, 8'h14);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h15, 6'b110010, 8'h15);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h16, 6'b110010, 8'h16);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h17, 6'b010000, 8'h17);
    v(3'b010, 8'd4, 8'd2, 1'b1, 8'h18, 6'b000001, 8'h17);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h18, 6'b000000, 8'h17);
    v(3'b010, 8'd0, 8'd5, 1'b1, 8'h18, 6'b000000, 8'h17);
    v(3'b000, 8'd0, 8'd5, 1'b1, 8'h18, 6'b000001, 8'h17);
    v(3'b000, 8'd0, 8'd5, 1'b1, 8'h18, 6'b000000, 8'h17);
    v(3'b010, 8'd3, 8'd0, 1'b1, 8'h18, 6'b000000, 8'h17);
    v(3'b000, 8'd3, 8'd0, 1'b1, 8'h18, 6'b000001, 8'h17);
    v(3'b010, 8'd4, 8'd2, 1'b1, 8'h30, 6'b100010, 8'h17);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h30, 6'b111110, 8'h30);
    v(3'b010, 8'd1, 8'd1, 1'b1, 8'h31, 6'b110010, 8'h31);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h32, 6'b110010, 8'h32);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h33, 6'b110010, 8'h33);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h34, 6'b110110, 8'h34);
    v(3'b110, 8'd4, 8'd2, 1'b1, 8'h35, 6'b000000, 8'h00);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h35, 6'b000000, 8'h00);
    v(3'b000, 8'd4, 8'd2, 1'b1, 8'h35, 6'b000000, 8'h00);

    foreach (vecs[i]) begin
      {Reset, Start, Abort} = vecs[i].ctl;
      Width = vecs[i].w; Height = vecs[i].h;
      SrcValid = vecs[i].sv; SrcPixel = vecs[i].pix;
      step();
      chk($sformatf("row%0d SrcReady", i), SrcReady, vecs[i].flags[5]);
      chk($sformatf("row%0d PixValid", i), PixValid, vecs[i].flags[4]);
      chk($sformatf("row%0d FrameOut", i), FrameOut, vecs[i].flags[3]);
      chk($sformatf("row%0d LineOut", i), LineOut, vecs[i].flags[2]);
      chk($sformatf("row%0d Busy", i), Busy, vecs[i].flags[1]);
      chk($sformatf("row%0d Done", i), Done, vecs[i].flags[0]);
      chk($sformatf("row%0d PixelOut", i), PixelOut, vecs[i].po);
    end

    // SrcValid toggling: transfers on odd cycles only, order preserved
    Width = 8'd4; Height = 8'd2; SrcValid = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    idx = 0; pvn = 0; bad = 0; done_at = 0;
    for (int n = 1; n <= 20; n++) begin
      SrcValid = (n % 2 == 1);
      SrcPixel = 8'h20 + 8'(idx);
      xr = SrcValid && SrcReady;
      step();
      if (xr) idx++;
      if (PixValid) begin
        if (PixelOut !== 8'h20 + 8'(pvn) || ((n + 1) % 2) != 0) bad++;
        pvn++;
      end
      if (Done) done_at = n + 1;
    end
    chk("toggle pixel count", pvn, 8);
    chk("toggle order/timing errors", bad, 0);
    chk("toggle done cycle", done_at, 17);
`else
    step();
    Reset = 1'b0;
    // Blanking: W=2, H=3, BLANK=3; SrcReady per cycle after Start
    pat = 14'b00110001100011;
    Width = 8'd2; Height = 8'd3; SrcValid = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      chk($sformatf("blank SrcReady c%0d", n), SrcReady, pat[n]);
      step();
    end
`endif
    Reset = 1'b0;

    // Abort after 3rd transfer of line 1
    Width = 8'd8; Height = 8'd4; SrcValid = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    xfers = 0; guard = 0;
    while (xfers < 11 && guard < 100) begin
      SrcPixel = 8'(xfers);
      xr = SrcReady;
      step();
      if (xr) xfers++;
      guard++;
    end
    chk("abort pre transfers", xfers, 11);
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("abort SrcReady", SrcReady, 1'b0);
    chk("abort PixValid", PixValid, 1'b0);
    chk("abort FrameOut", FrameOut, 1'b0);
    chk("abort LineOut", LineOut, 1'b0);
    chk("abort Busy", Busy, 1'b0);
    chk("abort Done", Done, 1'b0);
    cnt_pv = 0; cnt_dn = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (PixValid) cnt_pv++;
      if (Done) cnt_dn++;
    end
    chk("post-abort PixValid count", cnt_pv, 0);
    chk("post-abort Done count", cnt_dn, 0);
    run_frame(8, 4, "after abort");

    // Abort coinciding with the final transfer
    Width = 8'd2; Height = 8'd1; SrcValid = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    chk("final abort PixValid", PixValid, 1'b0);
    chk("final abort Busy", Busy, 1'b0);
    chk("final abort SrcReady", SrcReady, 1'b0);
    cnt_dn = 0;
    for (int n = 0; n < 4; n++) begin
      if (Done) cnt_dn++;
      step();
    end
    chk("final abort Done count", cnt_dn, 0);

    // Counter boundaries
    run_frame(255, 2, "w255");
    run_frame(1, 255, "h255");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
